alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered, flow-controlled successor to the combinational ALU controller. Accepts a full 32-bit RV32 instruction plus a sideband tag over a valid/ready handshake, decodes ALU operation, operand-B source and an illegal flag, and presents them through a 2-entry skid buffer. Sits between fetch/issue and execute, giving one-cycle decode latency at full throughput, plus pipeline flush.

## Interface
- IWIDTH, 32: instruction width; fields are opcode [6:0], funct3 [14:12], funct7 [31:25].
- AWIDTH, 5: ALU op width. Must be ≥5 when ALU_MEXT_EN is defined, ≥4 otherwise.
- TAGW, 8: sideband tag width, passed through unmodified.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered and incoming entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  stage can accept; equals !full (state TWO).
- in_instr  in  IWIDTH  instruction.
- in_tag  in  TAGW  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_aluop  out  AWIDTH  decoded ALU op.
- out_alusrc  out  1  1 = operand B is the immediate.
- out_illegal  out  1  instruction not decodable.
- out_tag  out  TAGW  tag of head entry.

## Operation
- ALU op codes: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9; with ALU_MEXT_EN: MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17 (funct3 000..111).
- R-type (0110011), alusrc 0: funct3 000 → ADD/SUB by funct7[5]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by funct7[5]; 110 OR; 111 AND. Legal funct7: 0000000 for all; 0100000 only with funct3 000/101.
- I-type (0010011), alusrc 1: same mapping, except funct3 000 is always ADD. For 001, funct7 must be 0000000. For 101, funct7 must be 0000000 or 0100000.
- LOAD 0000011, STORE 0100011, JALR 1100111, LUI 0110111, AUIPC 0010111: ADD, alusrc 1.
- BRANCH 1100011, JAL 1101111: ADD, alusrc 0.
- Any other opcode or illegal funct7: aluop ADD, alusrc 0, illegal 1.
- Skid buffer FSM EMPTY/ONE/TWO, FIFO order:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Push+pop in ONE stays in ONE.
  - Push+pop in TWO is impossible, since in_ready is 0.
- Head outputs hold stable while out_valid && !out_ready.
- flush has priority over push and pop: next state EMPTY, and a same-cycle input is dropped.

## Timing
- Reset values (async, immediate): state EMPTY, out_valid 0, out_aluop 0, out_alusrc 0, out_illegal 0, out_tag 0, in_ready 1.
- Latency: entry accepted at edge N is visible with out_valid=1 after edge N (cycle N+1).
- Throughput: 1 entry/cycle while out_ready is held high.
- in_ready is purely state-derived. It has no combinational path from out_ready.
- Reset asserted mid-transfer: all entries are lost and no partial output is produced.
- out_* payload registers are the only decode outputs. There is no combinational in→out path.

## Configuration
- ALU_MEXT_EN defined: R-type with funct7 0000001 decodes to MUL..REMU (codes 10-17), alusrc 0, illegal 0.
- ALU_MEXT_EN undefined: funct7 0000001 is illegal (aluop ADD, illegal 1); AWIDTH 4 is permitted.

## Test plan
- Reset then in_valid with 0x40B50533 (sub x10,x10,x11), tag 0x11, out_ready 1 → next cycle out_valid 1, aluop 1, alusrc 0, illegal 0, tag 0x11.
- 0x4020D093 (srai x1,x1,2) → aluop 7, alusrc 1. 0x0000007F → aluop 0, illegal 1.
- 0x023100B3 (mul x1,x2,x3) → aluop 10, illegal 0 with ALU_MEXT_EN; aluop 0, illegal 1 without.
- out_ready 0, push three back-to-back → in_ready falls after 2nd accept, 3rd held. Release out_ready → entries drain in order, head stable while stalled.
- State TWO, assert flush with in_valid 1 → next cycle out_valid 0, in_ready 1, flushed entries never emerge.
- Assert rst mid-stream with two entries buffered → out_valid 0 immediately, outputs zero, first post-reset push appears after 1 cycle.

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32 ALU decode behind a valid/ready handshake.
// Each accepted instruction is decoded into an ALU op, an operand-B source
// select and an illegal flag. The decoded entry is then held in a 2-entry skid
// buffer (states EMPTY/ONE/TWO, FIFO order) until it drains.
//
// Optional feature: define ALU_MEXT_EN to decode the RV32M group (funct7
// 0000001) into ALU ops MUL..REMU. AWIDTH must then be at least 5. Without the
// macro, AWIDTH 4 is sufficient and funct7 0000001 decodes as illegal.
//
// in_ready depends only on the state register, so no combinational path runs
// from out_ready to in_ready. Every out_* payload bit comes straight from a
// register.
module alu_decode_stage #(
  parameter int IWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int TAGW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_instr,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] out_aluop,
  output logic              out_alusrc,
  output logic              out_illegal,
  output logic [TAGW-1:0]   out_tag
);

  // ALU operation encodings
  localparam logic [AWIDTH-1:0] OP_ADD  = AWIDTH'(0);
  localparam logic [AWIDTH-1:0] OP_SUB  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] OP_XOR  = AWIDTH'(2);
  localparam logic [AWIDTH-1:0] OP_OR   = AWIDTH'(3);
  localparam logic [AWIDTH-1:0] OP_AND  = AWIDTH'(4);
  localparam logic [AWIDTH-1:0] OP_SLL  = AWIDTH'(5);
  localparam logic [AWIDTH-1:0] OP_SRL  = AWIDTH'(6);
  localparam logic [AWIDTH-1:0] OP_SRA  = AWIDTH'(7);
  localparam logic [AWIDTH-1:0] OP_SLT  = AWIDTH'(8);
  localparam logic [AWIDTH-1:0] OP_SLTU = AWIDTH'(9);
`ifdef ALU_MEXT_EN
  // MUL..REMU occupy 10..17 in funct3 order
  localparam logic [AWIDTH-1:0] OP_MUL  = AWIDTH'(10);
`endif

  // RV32 major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef ALU_MEXT_EN
  localparam logic [6:0] F7_MEXT = 7'b0000001;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [AWIDTH-1:0] aluop;
    logic              alusrc;
    logic              illegal;
    logic [TAGW-1:0]   tag;
  } entry_t;

  // Base-ISA funct3 mapping. alt selects SUB or SRA, the funct7[5] variants.
  function automatic logic [AWIDTH-1:0] map_funct3(input logic [2:0] f3,
                                                   input logic       alt);
    logic [AWIDTH-1:0] op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  // Register and immediate fields do not affect the ALU control
  assign unused_fields = ^{in_instr[24:15], in_instr[11:7]};

  state_e state_q, state_d;
  entry_t head_q, skid_q, dec;
  logic   push, pop;
  logic   load_head_in, load_head_skid, load_skid;

  // Decode the incoming instruction into an entry (combinational)
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    dec.aluop   = OP_ADD;
    dec.alusrc  = 1'b0;
    dec.illegal = 1'b0;
    dec.tag     = in_tag;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec.aluop = map_funct3(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.aluop = map_funct3(funct3, 1'b1);
`ifdef ALU_MEXT_EN
        end else if (funct7 == F7_MEXT) begin
          dec.aluop = OP_MUL + AWIDTH'(funct3);
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.alusrc = 1'b1;
        case (funct3)
          3'b000: dec.aluop = OP_ADD;
          3'b001: begin
            if (funct7 == F7_BASE) dec.aluop = OP_SLL;
            else                   dec.illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec.aluop = OP_SRL;
            else if (funct7 == F7_ALT) dec.aluop = OP_SRA;
            else                       dec.illegal = 1'b1;
          end
          default: dec.aluop = map_funct3(funct3, 1'b0);
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
        dec.aluop  = OP_ADD;
        dec.alusrc = 1'b1;
      end
      OPC_BRANCH, OPC_JAL: begin
        dec.aluop  = OP_ADD;
        dec.alusrc = 1'b0;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal instruction always presents ADD with register operand B
    if (dec.illegal) begin
      dec.aluop  = OP_ADD;
      dec.alusrc = 1'b0;
    end
  end

  // State register: occupancy of the skid buffer
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, whatever the evaluation order.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic: flush wins over push and pop
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = TWO;
          else if (!push && pop) state_d = EMPTY;
        end
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output and datapath-control logic derived from the current state
  always_comb begin
    in_ready       = (state_q != TWO);
    out_valid      = (state_q != EMPTY);
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    load_head_in   = !flush && push && ((state_q == EMPTY) || (state_q == ONE && pop));
    load_skid      = !flush && push && !pop && (state_q == ONE);
    load_head_skid = !flush && pop && (state_q == TWO);
  end

  // Payload registers: head feeds the outputs, skid holds the second entry
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the skid entry is reset along with the head, so no X can reach the outputs when the skid entry moves up.
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head_in)        head_q <= dec;
      else if (load_head_skid) head_q <= skid_q;
      if (load_skid)           skid_q <= dec;
    end
  end

  assign out_aluop   = head_q.aluop;
  assign out_alusrc  = head_q.alusrc;
  assign out_illegal = head_q.illegal;
  assign out_tag     = head_q.tag;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed self-checking bench for alu_decode_stage.
// Honours ALU_MEXT_EN in the same way as the design does.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_aluop;
  logic        out_alusrc;
  logic        out_illegal;
  logic [7:0]  out_tag;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  op;
    logic        src;
    logic        ill;
  } vec_t;

  alu_decode_stage #(.IWIDTH(32), .AWIDTH(5), .TAGW(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_alusrc(out_alusrc), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pack(input logic v, input logic [4:0] op,
                                       input logic src, input logic ill,
                                       input logic [7:0] tag);
    return {v, op, src, ill, tag};
  endfunction

  function automatic logic [15:0] observed();
    return {out_valid, out_aluop, out_alusrc, out_illegal, out_tag};
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [7:0] tag);
    in_valid = v;
    in_instr = instr;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    logic [15:0] exp_v;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    exp_v = pack(1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (observed() !== exp_v || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got %h ready=%b expected %h ready=1", observed(), in_ready, exp_v);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  // Back-to-back decode with out_ready high; each entry shows one cycle later
  task automatic test_decode();
    vec_t v[$];
    logic [15:0] exp_v;
    logic [7:0]  tag;
    v.push_back('{32'h40B50533, 5'd1, 1'b0, 1'b0}); // sub
    v.push_back('{32'h4020D093, 5'd7, 1'b1, 1'b0}); // srai
    v.push_back('{32'h0000007F, 5'd0, 1'b0, 1'b1}); // unknown opcode
`ifdef ALU_MEXT_EN
    v.push_back('{32'h023100B3, 5'd10, 1'b0, 1'b0}); // mul
    v.push_back('{32'h023170B3, 5'd17, 1'b0, 1'b0}); // remu
`else
    v.push_back('{32'h023100B3, 5'd0, 1'b0, 1'b1});
    v.push_back('{32'h023170B3, 5'd0, 1'b0, 1'b1});
`endif
    v.push_back('{32'h003100B3, 5'd0, 1'b0, 1'b0}); // add
    v.push_back('{32'h003140B3, 5'd2, 1'b0, 1'b0}); // xor
    v.push_back('{32'h003130B3, 5'd9, 1'b0, 1'b0}); // sltu
    v.push_back('{32'h403150B3, 5'd7, 1'b0, 1'b0}); // sra
    v.push_back('{32'h403140B3, 5'd0, 1'b0, 1'b1}); // xor with funct7 0100000
    v.push_back('{32'h00309093, 5'd5, 1'b1, 1'b0}); // slli
    v.push_back('{32'h40309093, 5'd0, 1'b0, 1'b1}); // slli with funct7 0100000
    v.push_back('{32'hFFF00093, 5'd0, 1'b1, 1'b0}); // addi -1
    v.push_back('{32'h0FF0F093, 5'd4, 1'b1, 1'b0}); // andi
    v.push_back('{32'h00012083, 5'd0, 1'b1, 1'b0}); // lw
    v.push_back('{32'h00112023, 5'd0, 1'b1, 1'b0}); // sw
    v.push_back('{32'h00208463, 5'd0, 1'b0, 1'b0}); // beq
    v.push_back('{32'h0000006F, 5'd0, 1'b0, 1'b0}); // jal
    v.push_back('{32'h000010B7, 5'd0, 1'b1, 1'b0}); // lui
    out_ready = 1'b1;
    foreach (v[i]) begin
      tag = 8'h11 + 8'(i);
      drive(1'b1, v[i].instr, tag);
      step();
      exp_v = pack(1'b1, v[i].op, v[i].src, v[i].ill, tag);
      checks++;
      if (observed() !== exp_v) begin
        failures++;
        $display("FAIL decode_%0d instr=%h: got %h expected %h", i, v[i].instr, observed(), exp_v);
      end
    end
    drive(1'b0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL decode_drain: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  // Fill both entries while stalled, then drain in FIFO order
  task automatic test_back_to_back();
    logic [15:0] exp_a, exp_b, exp_c;
    exp_a = pack(1'b1, 5'd1, 1'b0, 1'b0, 8'hA1); // sub
    exp_b = pack(1'b1, 5'd2, 1'b0, 1'b0, 8'hB2); // xor
    exp_c = pack(1'b1, 5'd5, 1'b1, 1'b0, 8'hC3); // slli
    out_ready = 1'b0;
    drive(1'b1, 32'h40B50533, 8'hA1);
    step();
    checks++;
    if (observed() !== exp_a || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_first: got %h ready=%b expected %h ready=1", observed(), in_ready, exp_a);
    end
    drive(1'b1, 32'h003140B3, 8'hB2);
    step();
    checks++;
    if (observed() !== exp_a || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_full: got %h ready=%b expected %h ready=0", observed(), in_ready, exp_a);
    end
    drive(1'b1, 32'h00309093, 8'hC3);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (observed() !== exp_a || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d: got %h ready=%b expected %h ready=0", k, observed(), in_ready, exp_a);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (observed() !== exp_b || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_second: got %h ready=%b expected %h ready=1", observed(), in_ready, exp_b);
    end
    step();
    checks++;
    if (observed() !== exp_c) begin
      failures++;
      $display("FAIL drain_third: got %h expected %h", observed(), exp_c);
    end
    drive(1'b0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: got valid=%b expected 0", out_valid);
    end
  endtask

  // Flush from state TWO with a simultaneous push
  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h003100B3, 8'h21);
    step();
    drive(1'b1, 32'h003130B3, 8'h22);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_setup: got ready=%b valid=%b expected ready=0 valid=1", in_ready, out_valid);
    end
    flush = 1'b1;
    drive(1'b1, 32'h00012083, 8'h23);
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_leak_%0d: got valid=%b tag=%h expected valid=0", k, out_valid, out_tag);
      end
    end
  endtask

  // Asynchronous reset with two entries buffered, then a fresh push
  task automatic test_reset_mid();
    logic [15:0] exp_v;
    out_ready = 1'b0;
    drive(1'b1, 32'h4020D093, 8'h31);
    step();
    drive(1'b1, 32'h403150B3, 8'h32);
    step();
    drive(1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    exp_v = pack(1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (observed() !== exp_v || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: got %h ready=%b expected %h ready=1", observed(), in_ready, exp_v);
    end
    #2 rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h0FF0F093, 8'h44);
    step();
    exp_v = pack(1'b1, 5'd4, 1'b1, 1'b0, 8'h44);
    checks++;
    if (observed() !== exp_v) begin
      failures++;
      $display("FAIL reset_repush: got %h expected %h", observed(), exp_v);
    end
    drive(1'b0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_final_empty: got valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    step();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
